// File: rtl/decoder_scan.sv
// decoder_scan: registered SEL_W-to-2^SEL_W one-hot decoder with an autonomous scan sequencer.
// Optional macro DECODER_SCAN_GRAY_EN makes the scan visit lines in reflected Gray order.
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  localparam int OUT_W  = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               scan_go_s;
  logic               expire_s;
  logic               last_s;
  logic [SEL_W-1:0]   idx_nxt_s;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  // Scan position to physical line; Gray build maps position i to i ^ (i >> 1).
  function automatic logic [SEL_W-1:0] line_of(input logic [SEL_W-1:0] i);
`ifdef DECODER_SCAN_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign scan_go_s = start & en & ((mode == MODE_CONT) | (mode == MODE_SINGLE));
  assign expire_s  = (dcnt_q == dwell_q);
  assign last_s    = (idx_q == SEL_W'(OUT_W - 1));
  assign idx_nxt_s = last_s ? {SEL_W{1'b0}} : (idx_q + SEL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (scan_go_s) state_d = S_SCAN;
        else           state_d = S_IDLE;
      end
      S_SCAN: begin
        // stop wins over a coincident final expiry, so no DONE visit then
        if (stop)                                                 state_d = S_IDLE;
        else if (en && expire_s && last_s && mode_q == MODE_SINGLE) state_d = S_DONE;
        else                                                      state_d = S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    dwell_d   = dwell_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    out_d     = '0;
    cur_sel_d = cur_sel_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode == MODE_DIRECT) begin
          out_d     = en ? onehot(sel_in) : '0;
          cur_sel_d = sel_in;
        end else if (scan_go_s) begin
          mode_d    = mode;
          dwell_d   = dwell;
          idx_d     = '0;
          dcnt_d    = '0;
          out_d     = onehot(line_of('0));
          cur_sel_d = line_of('0);
          busy_d    = 1'b1;
        end else begin
          out_d = '0;
        end
      end
      S_SCAN: begin
        if (stop) begin
          idx_d  = '0;
          dcnt_d = '0;
        end else if (!en) begin
          busy_d = 1'b1;
        end else if (!expire_s) begin
          dcnt_d    = dcnt_q + DWELL_W'(1);
          out_d     = onehot(line_of(idx_q));
          cur_sel_d = line_of(idx_q);
          busy_d    = 1'b1;
        end else if (last_s && mode_q == MODE_SINGLE) begin
          idx_d  = '0;
          dcnt_d = '0;
          done_d = 1'b1;
        end else begin
          dcnt_d    = '0;
          idx_d     = idx_nxt_s;
          out_d     = onehot(line_of(idx_nxt_s));
          cur_sel_d = line_of(idx_nxt_s);
          busy_d    = 1'b1;
        end
      end
      S_DONE: begin
        out_d = '0;
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 2'd0;
      dwell_q   <= '0;
      idx_q     <= '0;
      dcnt_q    <= '0;
      out_q     <= '0;
      cur_sel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      dwell_q   <= dwell_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
